// File: rtl/registers_pkg.sv
// rtl/registers_pkg.sv - shared register access aliases, write helpers and irq controller enums
package registers;

    typedef enum logic [1:0] {
        REG_MAIN = 2'd0,
        REG_SET  = 2'd1,
        REG_CLR  = 2'd2,
        REG_INV  = 2'd3
    } reg_access_t;

    typedef enum {IRQ_IDLE, IRQ_PEND, IRQ_SERV} irq_state_t;

    typedef enum logic [1:0] {R_ENABLE, R_STATUS, R_MODE, R_ACTIVE} irq_reg_t;

    function automatic logic [31:0] writeval(input reg_access_t acc, input logic [31:0] cur,
                                             input logic [31:0] wdata);
        logic [31:0] res;
        case (acc)
            REG_MAIN: res = wdata;
            REG_SET:  res = cur | wdata;
            REG_CLR:  res = cur & ~wdata;
            REG_INV:  res = cur ^ wdata;
            default:  res = cur;
        endcase
        return res;
    endfunction

    // Software may only clear; SET is meaningless for a hardware-set register.
    function automatic logic [31:0] clearonly(input reg_access_t acc, input logic [31:0] cur,
                                              input logic [31:0] wdata);
        logic [31:0] res;
        if (acc == REG_SET) res = cur;
        else                res = cur & ~wdata;
        return res;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - one-bit two-flop synchroniser with rising-edge detect
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - bus-mapped interrupt controller with status latching and ack/EOI FSM
module irq_controller
    import registers::*;
#(
    parameter int N_SRC = 16,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [3:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ready_o,
    output logic             irq_o,
    input  logic             irq_ack_i,
    input  logic             irq_eoi_i,
    output logic [ID_W-1:0]  irq_id_o
);

    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] status_q, status_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    irq_state_t       state_q, state_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [31:0]      rd_hold_q, rd_hold_d;
    logic             rd_vld_q, rd_vld_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;

    logic [N_SRC-1:0] sync_v, rise_v;
    logic [N_SRC-1:0] pending, hw_set, ack_clr, status_sw;
    logic [ID_W-1:0]  winner;
    logic             ack_take, wr;
    irq_reg_t         sel;
    reg_access_t      acc;
    logic [31:0]      wv_enable, wv_mode, cv_status, rd_val;
    logic             unused_bits;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst    (rst),
            .d_i    (src_i[g]),
            .sync_o (sync_v[g]),
            .rise_o (rise_v[g])
        );
    end

    function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    assign sel       = irq_reg_t'(addr_i[3:2]);
    assign acc       = reg_access_t'(addr_i[1:0]);
    assign wr        = req_i & we_i;
    assign wv_enable = writeval(acc, 32'(enable_q), wdata_i);
    assign wv_mode   = writeval(acc, 32'(mode_q), wdata_i);
    assign cv_status = clearonly(acc, 32'(status_q), wdata_i);
    assign pending   = status_q & enable_q;
    assign winner    = lowest_set(pending);
    // Ack is honoured only if something is still pending in the same cycle.
    assign ack_take  = (state_q == IRQ_PEND) && irq_ack_i && (|pending);
    assign ack_clr   = ack_take ? (N_SRC'(1) << winner) : '0;
    assign hw_set    = (mode_q & rise_v) | (~mode_q & sync_v);
    assign unused_bits = ^{wv_enable, wv_mode, cv_status, wdata_i};

    always_comb begin
        enable_d  = enable_q;
        mode_d    = mode_q;
        status_sw = status_q;
        if (wr) begin
            case (sel)
                R_ENABLE: enable_d  = wv_enable[N_SRC-1:0];
                R_STATUS: status_sw = cv_status[N_SRC-1:0];
                R_MODE:   mode_d    = wv_mode[N_SRC-1:0];
                default:  ;
            endcase
        end
        // Hardware set overrides a software clear; the ack clear overrides both.
        status_d = (status_sw | hw_set) & ~ack_clr;
    end

    always_comb begin
        case (sel)
            R_ENABLE: rd_val = 32'(enable_q);
            R_STATUS: rd_val = 32'(status_q);
            R_MODE:   rd_val = 32'(mode_q);
            default: begin
                rd_val     = 32'(irq_id_q);
                rd_val[31] = (state_q == IRQ_SERV);
            end
        endcase
        rd_hold_d = (req_i && !we_i) ? rd_val : '0;
        rd_vld_d  = req_i;
        rdata_d   = rd_hold_q;
        ready_d   = rd_vld_q;
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IRQ_IDLE: if (|pending) state_d = IRQ_PEND;
            IRQ_PEND: begin
                if (!(|pending)) begin
                    state_d = IRQ_IDLE;
                end else if (ack_take) begin
                    state_d  = IRQ_SERV;
                    irq_id_d = winner;
                end
            end
            IRQ_SERV: if (irq_eoi_i) state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q  <= '0;
            status_q  <= '0;
            mode_q    <= '0;
            state_q   <= IRQ_IDLE;
            irq_id_q  <= '0;
            rd_hold_q <= '0;
            rd_vld_q  <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            status_q  <= status_d;
            mode_q    <= mode_d;
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            rd_hold_q <= rd_hold_d;
            rd_vld_q  <= rd_vld_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign ready_o  = ready_q;
    assign irq_o    = (state_q == IRQ_PEND);
    assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    localparam int N_SRC = 16;
    localparam int ID_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] src_i;
    logic             req_i, we_i;
    logic [3:0]       addr_i;
    logic [31:0]      wdata_i;
    logic [31:0]      rdata_o;
    logic             ready_o, irq_o, irq_ack_i, irq_eoi_i;
    logic [ID_W-1:0]  irq_id_o;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] A_EN_MAIN = 4'd0, A_EN_SET = 4'd1, A_EN_CLR = 4'd2, A_EN_INV = 4'd3;
    localparam logic [3:0] A_ST_MAIN = 4'd4, A_ST_SET = 4'd5, A_ST_CLR = 4'd6;
    localparam logic [3:0] A_MD_MAIN = 4'd8, A_ACTIVE = 4'd12;

    irq_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .src_i(src_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .ready_o(ready_o), .irq_o(irq_o),
        .irq_ack_i(irq_ack_i), .irq_eoi_i(irq_eoi_i), .irq_id_o(irq_id_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        tick();
        req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic rdy);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        tick();
        req_i = 1'b0;
        tick();
        d = rdata_o;
        rdy = ready_o;
    endtask

    task automatic pulse_src(input logic [N_SRC-1:0] m);
        src_i = m;
        tick();
        src_i = '0;
    endtask

    task automatic do_ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic do_eoi();
        irq_eoi_i = 1'b1;
        tick();
        irq_eoi_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic rdy;
        rst = 1'b1;
        ticks(2);
        checks++; if ({irq_o, ready_o, irq_id_o, rdata_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: got irq=%0b rdy=%0b id=%0d rdata=%h required all 0",
                               irq_o, ready_o, irq_id_o, rdata_o); end
        rst = 1'b0;
        tick();
        req_i = 1'b1; we_i = 1'b0; addr_i = A_EN_MAIN;
        tick();
        req_i = 1'b0;
        checks++; if (ready_o !== 1'b0) begin
            errors++; $display("FAIL ready_early: got %0b required 0", ready_o); end
        tick();
        checks++; if (ready_o !== 1'b1 || rdata_o !== 32'h0) begin
            errors++; $display("FAIL ready_read_enable: got rdy=%0b data=%h required 1/0", ready_o, rdata_o); end
        tick();
        checks++; if (ready_o !== 1'b0) begin
            errors++; $display("FAIL ready_one_cycle: got %0b required 0", ready_o); end
        bus_read(A_ACTIVE, d, rdy);
        checks++; if (d !== 32'h0 || rdy !== 1'b1) begin
            errors++; $display("FAIL reset_active: got %h required 00000000", d); end
    endtask

    task automatic test_enable_alias();
        logic [31:0] d;
        logic rdy;
        bus_write(A_EN_MAIN, 32'h5);
        bus_write(A_EN_SET, 32'h2);
        bus_read(A_EN_MAIN, d, rdy);
        checks++; if (d !== 32'h7) begin
            errors++; $display("FAIL enable_set: got %h required 00000007", d); end
        bus_write(A_EN_INV, 32'h4);
        bus_read(A_EN_CLR, d, rdy);
        checks++; if (d !== 32'h3) begin
            errors++; $display("FAIL enable_inv: got %h required 00000003", d); end
        bus_write(A_EN_MAIN, 32'hFFFF_FFFF);
        bus_read(A_EN_MAIN, d, rdy);
        checks++; if (d !== 32'h0000_FFFF) begin
            errors++; $display("FAIL enable_upper_bits: got %h required 0000ffff", d); end
        bus_write(A_EN_MAIN, 32'h0);
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        logic rdy;
        bus_write(A_MD_MAIN, 32'h8);
        bus_write(A_EN_MAIN, 32'h8);
        pulse_src(16'h0008);
        tick();
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL edge_irq_k1: got %0b required 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL edge_irq_k2: got %0b required 0", irq_o); end
        req_i = 1'b1; we_i = 1'b0; addr_i = A_ST_MAIN;
        tick();
        req_i = 1'b0;
        checks++; if (irq_o !== 1'b1) begin
            errors++; $display("FAIL edge_irq_k3: got %0b required 1", irq_o); end
        tick();
        checks++; if (rdata_o !== 32'h8 || ready_o !== 1'b1) begin
            errors++; $display("FAIL edge_status_k2: got %h required 00000008", rdata_o); end
        do_ack();
        checks++; if (irq_id_o !== 5'd3 || irq_o !== 1'b0) begin
            errors++; $display("FAIL edge_ack: got id=%0d irq=%0b required 3/0", irq_id_o, irq_o); end
        bus_read(A_ST_MAIN, d, rdy);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL edge_status_after_ack: got %h required 00000000", d); end
        bus_read(A_ACTIVE, d, rdy);
        checks++; if (d !== 32'h8000_0003) begin
            errors++; $display("FAIL active_in_service: got %h required 80000003", d); end
        do_eoi();
        bus_read(A_ACTIVE, d, rdy);
        checks++; if (d[31] !== 1'b0 || d[ID_W-1:0] !== 5'd3) begin
            errors++; $display("FAIL active_after_eoi: got %h required bit31=0 id=3", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        logic rdy;
        bus_write(A_MD_MAIN, 32'h24);
        bus_write(A_EN_MAIN, 32'h24);
        pulse_src(16'h0024);
        ticks(4);
        checks++; if (irq_o !== 1'b1) begin
            errors++; $display("FAIL prio_irq: got %0b required 1", irq_o); end
        do_ack();
        checks++; if (irq_id_o !== 5'd2) begin
            errors++; $display("FAIL prio_first_id: got %0d required 2", irq_id_o); end
        bus_read(A_ST_MAIN, d, rdy);
        checks++; if (d !== 32'h20) begin
            errors++; $display("FAIL prio_status: got %h required 00000020", d); end
        do_eoi();
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL prio_eoi_idle: got %0b required 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1) begin
            errors++; $display("FAIL prio_reassert: got %0b required 1", irq_o); end
        do_ack();
        checks++; if (irq_id_o !== 5'd5) begin
            errors++; $display("FAIL prio_second_id: got %0d required 5", irq_id_o); end
        do_eoi();
    endtask

    task automatic test_level_hw_wins();
        logic [31:0] d;
        logic rdy;
        bus_write(A_EN_MAIN, 32'h0);
        bus_write(A_MD_MAIN, 32'h0);
        src_i = 16'h0002;
        ticks(4);
        for (int i = 0; i < 4; i++) bus_write(A_ST_CLR, 32'h2);
        bus_read(A_ST_MAIN, d, rdy);
        checks++; if (d !== 32'h2) begin
            errors++; $display("FAIL level_hw_wins: got %h required 00000002", d); end
        src_i = '0;
        ticks(3);
        bus_write(A_ST_CLR, 32'h2);
        bus_read(A_ST_MAIN, d, rdy);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL level_cleared: got %h required 00000000", d); end
        bus_write(A_ST_SET, 32'h1);
        bus_read(A_ST_MAIN, d, rdy);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL status_set_ignored: got %h required 00000000", d); end
    endtask

    task automatic test_disable_drop();
        logic [31:0] d;
        logic rdy;
        bus_write(A_MD_MAIN, 32'h10);
        bus_write(A_EN_MAIN, 32'h10);
        pulse_src(16'h0010);
        ticks(4);
        checks++; if (irq_o !== 1'b1) begin
            errors++; $display("FAIL drop_pend: got %0b required 1", irq_o); end
        bus_write(A_EN_CLR, 32'h10);
        checks++; if (irq_o !== 1'b1) begin
            errors++; $display("FAIL drop_same_edge: got %0b required 1", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b0) begin
            errors++; $display("FAIL drop_next_cycle: got %0b required 0", irq_o); end
        do_ack();
        checks++; if (irq_id_o !== 5'd5 || irq_o !== 1'b0) begin
            errors++; $display("FAIL stray_ack: got id=%0d irq=%0b required 5/0", irq_id_o, irq_o); end
        bus_read(A_ACTIVE, d, rdy);
        checks++; if (d !== 32'h0000_0005) begin
            errors++; $display("FAIL stray_ack_active: got %h required 00000005", d); end
        bus_write(A_ST_MAIN, 32'h10);
    endtask

    task automatic test_reset_in_service();
        logic [31:0] d;
        logic rdy;
        bus_write(A_MD_MAIN, 32'h41);
        bus_write(A_EN_MAIN, 32'h40);
        pulse_src(16'h0040);
        ticks(4);
        do_ack();
        checks++; if (irq_id_o !== 5'd6) begin
            errors++; $display("FAIL serv_id: got %0d required 6", irq_id_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (irq_o !== 1'b0 || irq_id_o !== '0) begin
            errors++; $display("FAIL rst_serv_out: got irq=%0b id=%0d required 0/0", irq_o, irq_id_o); end
        bus_read(A_EN_MAIN, d, rdy);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL rst_enable: got %h required 00000000", d); end
        bus_read(A_MD_MAIN, d, rdy);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL rst_mode: got %h required 00000000", d); end
        do_eoi();
        bus_read(A_ACTIVE, d, rdy);
        checks++; if (d !== 32'h0 || irq_o !== 1'b0) begin
            errors++; $display("FAIL rst_stray_eoi: got %h irq=%0b required 00000000/0", d, irq_o); end
    endtask

    initial begin
        rst = 1'b1; src_i = '0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        irq_ack_i = 1'b0; irq_eoi_i = 1'b0;
        test_reset();
        test_enable_alias();
        test_edge_irq();
        test_priority();
        test_level_hw_wins();
        test_disable_drop();
        test_reset_in_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
